fetch_queue: RTL and testbench

Parametrised instruction-fetch unit with a decoupling prefetch queue for the pipelined CPU, replacing the single-entry PC register plus IF/ID stall-enable pair. It sequences the fetch PC, captures words from the combinational instruction port of `memory`, and buffers up to DEPTH fetched instructions ahead of decode. It also absorbs branch/jump redirects from the later stages by flushing the queue. Decode consumes entries through a valid/ready handshake.

---
 rtl/fetch_queue.sv | 80 ++++++++
 tb/tb_fetch_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch unit: sequences the fetch PC and buffers fetched words
// in a DEPTH-entry prefetch queue ahead of decode, flushed on redirect.
module fetch_queue #(
  parameter int unsigned           WIDTH    = 32,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic [WIDTH-1:0]           imem_data,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [WIDTH-1:0]           id_instr,
  output logic [WIDTH-1:0]           id_pcplus4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] fetch_pcplus4;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [WIDTH-1:0] instr_mem  [DEPTH];
  logic [WIDTH-1:0] pcplus4_mem[DEPTH];
  logic             pop;
  logic             push;

  assign fetch_pcplus4 = fetch_pc + WIDTH'(4);
  assign imem_addr     = fetch_pc;
  assign id_valid      = (count != '0);
  assign pop           = id_valid & id_ready;
  assign push          = !redirect & ((count != FULL) | pop);

  // Storage is never reset; outputs are masked while the queue is empty.
  assign id_instr   = id_valid ? instr_mem[head]   : '0;
  assign id_pcplus4 = id_valid ? pcplus4_mem[head] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pcplus4;
        tail     <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // A push is already suppressed by redirect; reset must block it too so
  // a reset cycle leaves no trace in storage-visible state.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem[tail]   <= imem_data;
      pcplus4_mem[tail] <= fetch_pcplus4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: main instance at RESET_PC=0 and a second
// instance at RESET_PC=FFFFFFFC for address wrap and pointer wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, redirect, id_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data, id_instr, id_pcplus4;
  logic        id_valid;
  logic [2:0]  count;

  logic        w_reset, w_ready;
  logic [31:0] w_addr, w_data, w_instr, w_pcplus4;
  logic        w_valid;
  logic [2:0]  w_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 32'hA5A50000;
  assign w_data    = w_addr ^ 32'hA5A50000;

  fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pcplus4(id_pcplus4),
    .count(count)
  );

  fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .imem_addr(w_addr), .imem_data(w_data),
    .redirect(1'b0), .redirect_pc(32'h0), .id_ready(w_ready),
    .id_valid(w_valid), .id_instr(w_instr), .id_pcplus4(w_pcplus4),
    .count(w_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] addr, input logic [2:0] cnt);
    check({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
    check({tag, "_instr"}, id_instr, addr ^ 32'hA5A50000);
    check({tag, "_pc4"}, id_pcplus4, addr + 32'd4);
    check({tag, "_count"}, {29'b0, count}, {29'b0, cnt});
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    w_reset = 1'b1; w_ready = 1'b0;
    step(); step();

    // Reset state
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc4", id_pcplus4, 32'h0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("w_rst_addr", w_addr, 32'hFFFFFFFC);

    // Fill with id_ready low
    reset = 1'b0; w_reset = 1'b0;
    step();
    check_head("fill1", 32'h0, 3'd1);
    check("fill1_addr", imem_addr, 32'h4);
    check("w_first_pc4", w_pcplus4, 32'h0);
    check("w_first_instr", w_instr, 32'h5A5AFFFC);
    check("w_next_addr", w_addr, 32'h0);
    step(); step(); step();
    check("full_count", {29'b0, count}, 32'd4);
    check("full_addr", imem_addr, 32'h10);
    step();
    check_head("full_hold", 32'h0, 3'd4);
    check("full_hold_addr", imem_addr, 32'h10);
    check("w_full_count", {29'b0, w_count}, 32'd4);
    check("w_full_addr", w_addr, 32'hC);

    // Full with a single-cycle pop
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check_head("fullpop", 32'h4, 3'd4);
    check("fullpop_addr", imem_addr, 32'h14);

    // Drain: no gap, loss or duplicate; includes word pushed during fullpop
    id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_head("drain", 32'h8 + 32'(4 * k), 3'd4);
    end
    check("drain_addr", imem_addr, 32'h2C);

    // Redirect colliding with a pop: flush wins
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0; id_ready = 1'b0;
    check("rdpop_count", {29'b0, count}, 32'd0);
    check("rdpop_valid", {31'b0, id_valid}, 32'd0);
    check("rdpop_instr", id_instr, 32'h0);
    check("rdpop_addr", imem_addr, 32'h200);
    step(); step(); step();
    check_head("three", 32'h200, 3'd3);

    // Redirect at count 3 with unaligned target
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    check("rd_count", {29'b0, count}, 32'd0);
    check("rd_valid", {31'b0, id_valid}, 32'd0);
    check("rd_addr", imem_addr, 32'h100);
    step();
    check_head("rd_target", 32'h100, 3'd1);

    // Reset and redirect together: reset wins
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; id_ready = 1'b1;
    step();
    check("rstrd_addr", imem_addr, 32'h0);
    check("rstrd_count", {29'b0, count}, 32'd0);

    // Streaming one instruction per cycle
    reset = 1'b0; redirect = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_head("stream", 32'(4 * k), 3'd1);
    end

    // Wrap instance: FIFO order across pointer wrap
    w_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("w_drain_valid", {31'b0, w_valid}, 32'd1);
      check("w_drain_instr", w_instr, 32'(4 * k) ^ 32'hA5A50000);
      check("w_drain_pc4", w_pcplus4, 32'(4 * k + 4));
      check("w_drain_count", {29'b0, w_count}, 32'd4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
